stoch_gen: RTL and testbench

STOCH_GEN -- requirements
Module: stoch_gen

---
 rtl/stoch_gen.sv | 109 ++++++++++
 tb/tb_stoch_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/stoch_gen.sv
// Stochastic bitstream pair generator: emits 2^WIDTH-1 bit pairs whose ones
// counts equal val_a/val_b, using WIDTH-bit maximal-length Fibonacci LFSRs.
module stoch_gen #(
  parameter int WIDTH  = 8,
  parameter int SEED_A = 1,
  parameter int SEED_B = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] val_a,
  input  logic [WIDTH-1:0] val_b,
  input  logic             corr,
  input  logic             hold,
  output logic             busy,
  output logic             bit_a,
  output logic             bit_b,
  output logic             bit_vld,
  output logic             done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int MASK = (1 << WIDTH) - 1;

  // Seeds are folded into WIDTH bits; an all-zero seed would lock the LFSR.
  localparam int SA_M = SEED_A & MASK;
  localparam int SB_M = SEED_B & MASK;
  localparam int SA_C = (SA_M == 0) ? 1 : SA_M;
  localparam int SB_C = (SB_M == 0) ? 1 : SB_M;
  localparam logic [WIDTH-1:0] SA = SA_C[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SB = SB_C[WIDTH-1:0];

  localparam int LAST_I = MASK - 1;
  localparam logic [WIDTH-1:0] LAST = LAST_I[WIDTH-1:0];

  // Tap masks for shift-left Fibonacci form, bit i = x^(i+1) term.
  localparam logic [7:0] TAPS = (WIDTH == 4) ? 8'h0C :
                                (WIDTH == 5) ? 8'h14 :
                                (WIDTH == 6) ? 8'h30 :
                                (WIDTH == 7) ? 8'h60 : 8'hB8;
  localparam logic [WIDTH-1:0] TAP_W = TAPS[WIDTH-1:0];

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAP_W)};
  endfunction

  logic [0:0]       state;
  logic [WIDTH-1:0] lfsr_a, lfsr_b, cnt, va_q, vb_q;
  logic             corr_q;
  logic [WIDTH-1:0] rng_b;

  assign rng_b = corr_q ? lfsr_a : lfsr_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      bit_a   <= 1'b0;
      bit_b   <= 1'b0;
      bit_vld <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      lfsr_a  <= SA;
      lfsr_b  <= SB;
      va_q    <= '0;
      vb_q    <= '0;
      corr_q  <= 1'b0;
    end else begin
      bit_a   <= 1'b0;
      bit_b   <= 1'b0;
      bit_vld <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            va_q   <= val_a;
            vb_q   <= val_b;
            corr_q <= corr;
            lfsr_a <= SA;
            lfsr_b <= SB;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (!hold) begin
            // rng spans 1..L exactly once, so (rng <= val) yields val ones.
            bit_a   <= (lfsr_a <= va_q);
            bit_b   <= (rng_b <= vb_q);
            bit_vld <= 1'b1;
            lfsr_a  <= lfsr_next(lfsr_a);
            lfsr_b  <= lfsr_next(lfsr_b);
            cnt     <= cnt + 1'b1;
            if (cnt == LAST) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stoch_gen.sv
// Directed bench for stoch_gen (WIDTH=8): table of stream runs plus
// hand sequences for ignored start, back-to-back runs and mid-run reset.
module tb_stoch_gen;

  logic       clk = 1'b0;
  logic       rst_n, start, corr, hold;
  logic [7:0] val_a, val_b;
  logic       busy, bit_a, bit_b, bit_vld, done;

  int tests = 0;
  int failed = 0;

  stoch_gen #(.WIDTH(8), .SEED_A(1), .SEED_B(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .val_a(val_a), .val_b(val_b),
    .corr(corr), .hold(hold), .busy(busy), .bit_a(bit_a), .bit_b(bit_b),
    .bit_vld(bit_vld), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va, vb;
    logic       c, htog;
    int         ea, eb;
    int         rel;   // 0: no relation, 1: seq_a==seq_b, 2: seq_a!=seq_b
  } vec_t;

  int r_ones_a, r_ones_b, r_pairs, r_cycles, r_done_bad, r_busy_bad;
  int r_impl_bad, r_held_bad, r_idle_bad, r_model_bad;
  logic r_timeout, r_first_vld;
  logic [254:0] r_seq_a, r_seq_b, p_seq_a, p_seq_b;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] mnext(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // One run from the capture edge to done; inputs driven and outputs sampled
  // on the falling edge.
  task automatic run(input logic [7:0] va, input logic [7:0] vb, input logic c,
                     input logic htog, input logic prestarted, input int poke_at,
                     input logic chain, input logic [7:0] nva,
                     input logic [7:0] nvb, input logic nc);
    logic [7:0] sa, sb;
    logic h_prev, ea, eb;
    int n;
    r_ones_a = 0; r_ones_b = 0; r_pairs = 0; r_cycles = 0; r_done_bad = 0;
    r_busy_bad = 0; r_impl_bad = 0; r_held_bad = 0; r_idle_bad = 0;
    r_model_bad = 0; r_timeout = 1'b0; r_seq_a = '0; r_seq_b = '0;
    if (!prestarted) begin
      val_a = va; val_b = vb; corr = c;
    end
    start = 1'b1;
    hold  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    val_a = ~va; val_b = ~vb; corr = ~c;   // captured values must stick
    r_first_vld = bit_vld;
    if (!busy) r_busy_bad++;
    sa = 8'h01; sb = 8'h05;
    hold = htog;
    n = 0;
    while (1) begin
      h_prev = hold;
      @(negedge clk);
      n++;
      r_cycles = n;
      start = 1'b0;
      if (bit_vld !== !h_prev) r_held_bad++;
      if (bit_vld) begin
        ea = (sa <= va);
        eb = ((c ? sa : sb) <= vb);
        if (bit_a !== ea || bit_b !== eb) r_model_bad++;
        if (c && va <= vb && bit_a && !bit_b) r_impl_bad++;
        if (r_pairs < 255) begin
          r_seq_a[r_pairs] = bit_a;
          r_seq_b[r_pairs] = bit_b;
        end
        r_ones_a += int'(bit_a);
        r_ones_b += int'(bit_b);
        r_pairs++;
        sa = mnext(sa);
        sb = mnext(sb);
      end else if (bit_a || bit_b || done) begin
        r_idle_bad++;
      end
      if (poke_at >= 0 && r_pairs == poke_at && bit_vld) begin
        val_a = 8'h11; val_b = 8'h22;
        start = 1'b1;
      end
      if (done) begin
        if (r_pairs != 255) r_done_bad++;
        if (busy) r_busy_bad++;
        if (chain) begin
          val_a = nva; val_b = nvb; corr = nc;
          start = 1'b1;
        end
        break;
      end
      if (!busy) r_busy_bad++;
      if (htog) hold = ~hold;
      if (n > 2000) begin
        r_timeout = 1'b1;
        break;
      end
    end
    hold = 1'b0;
  endtask

  task automatic check_run(input string nm, input int ea, input int eb, input int ecyc);
    chk({nm, " timeout"}, int'(r_timeout), 0);
    chk({nm, " first_vld"}, int'(r_first_vld), 0);
    chk({nm, " ones_a"}, r_ones_a, ea);
    chk({nm, " ones_b"}, r_ones_b, eb);
    chk({nm, " pairs"}, r_pairs, 255);
    chk({nm, " cycles"}, r_cycles, ecyc);
    chk({nm, " done_pos"}, r_done_bad, 0);
    chk({nm, " busy"}, r_busy_bad, 0);
    chk({nm, " vld_vs_hold"}, r_held_bad, 0);
    chk({nm, " idle_zero"}, r_idle_bad, 0);
    chk({nm, " model"}, r_model_bad, 0);
    chk({nm, " implication"}, r_impl_bad, 0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{va: 8'h80, vb: 8'hFF, c: 1'b1, htog: 1'b0, ea: 128, eb: 255, rel: 0};
    vecs[1] = '{va: 8'h00, vb: 8'h40, c: 1'b0, htog: 1'b0, ea: 0,   eb: 64,  rel: 2};
    vecs[2] = '{va: 8'h30, vb: 8'h60, c: 1'b1, htog: 1'b0, ea: 48,  eb: 96,  rel: 0};
    vecs[3] = '{va: 8'hA5, vb: 8'h3C, c: 1'b0, htog: 1'b1, ea: 165, eb: 60,  rel: 0};
    vecs[4] = '{va: 8'h40, vb: 8'h40, c: 1'b0, htog: 1'b0, ea: 64,  eb: 64,  rel: 2};
    vecs[5] = '{va: 8'h40, vb: 8'h40, c: 1'b1, htog: 1'b0, ea: 64,  eb: 64,  rel: 1};
    vecs[6] = '{va: 8'hFF, vb: 8'h00, c: 1'b1, htog: 1'b0, ea: 255, eb: 0,   rel: 0};
    vecs[7] = '{va: 8'h01, vb: 8'hFE, c: 1'b0, htog: 1'b1, ea: 1,   eb: 254, rel: 0};

    rst_n = 1'b0; start = 1'b0; corr = 1'b0; hold = 1'b0;
    val_a = 8'h00; val_b = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset outputs", int'({busy, bit_vld, bit_a, bit_b, done}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle outputs", int'({busy, bit_vld, bit_a, bit_b, done}), 0);

    for (int i = 0; i < 8; i++) begin
      run(vecs[i].va, vecs[i].vb, vecs[i].c, vecs[i].htog, 1'b0, -1, 1'b0, 8'h00, 8'h00, 1'b0);
      check_run($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].htog ? 510 : 255);
      if (vecs[i].rel == 1) chk($sformatf("vec%0d seq_same", i), int'(r_seq_a == r_seq_b), 1);
      if (vecs[i].rel == 2) chk($sformatf("vec%0d seq_differ", i), int'(r_seq_a != r_seq_b), 1);
      if (i == 0) begin
        p_seq_a = r_seq_a;
        p_seq_b = r_seq_b;
      end
      @(negedge clk);
      chk($sformatf("vec%0d after_done", i), int'({busy, bit_vld, bit_a, bit_b, done}), 0);
    end

    // start while busy is ignored
    run(8'h55, 8'hAA, 1'b0, 1'b0, 1'b0, 10, 1'b0, 8'h00, 8'h00, 1'b0);
    check_run("poke", 85, 170, 255);
    @(negedge clk);
    chk("poke no_restart", int'(busy), 0);

    // start in the done cycle: one idle cycle between runs
    run(8'h30, 8'h60, 1'b1, 1'b0, 1'b0, -1, 1'b1, 8'h10, 8'h20, 1'b0);
    check_run("b2b_first", 48, 96, 255);
    run(8'h10, 8'h20, 1'b0, 1'b0, 1'b1, -1, 1'b0, 8'h00, 8'h00, 1'b0);
    check_run("b2b_second", 16, 32, 255);

    // asynchronous reset at pair 100, then a fresh run
    begin
      int pairs;
      int n;
      pairs = 0;
      n = 0;
      val_a = 8'h80; val_b = 8'hFF; corr = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (pairs < 100 && n < 1000) begin
        @(negedge clk);
        n++;
        if (bit_vld) pairs++;
      end
      chk("rst reach_pair100", pairs, 100);
      chk("rst busy_before", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1 chk("rst async_outputs", int'({busy, bit_vld, bit_a, bit_b, done}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst no_resume", int'({busy, bit_vld, bit_a, bit_b, done}), 0);
      run(8'h80, 8'hFF, 1'b1, 1'b0, 1'b0, -1, 1'b0, 8'h00, 8'h00, 1'b0);
      check_run("post_rst", 128, 255, 255);
      chk("post_rst seq_a", int'(r_seq_a == p_seq_a), 1);
      chk("post_rst seq_b", int'(r_seq_b == p_seq_b), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
